// File: rtl/display_controller_if.sv
// Request/result bundle for the binary-to-BCD display controller.
// The requester drives in_valid/in_value; the controller drives the rest.
interface display_controller_if;
    logic        in_valid;
    logic [19:0] in_value;
    logic        in_ready;
    logic        busy;
    logic [23:0] digits;
    logic [5:0]  digit_en;
    logic        overflow;
    logic        out_valid;

    // Requester side
    modport master (
        output in_valid,
        output in_value,
        input  in_ready,
        input  busy,
        input  digits,
        input  digit_en,
        input  overflow,
        input  out_valid
    );

    // Controller side
    modport slave (
        input  in_valid,
        input  in_value,
        output in_ready,
        output busy,
        output digits,
        output digit_en,
        output overflow,
        output out_valid
    );
endinterface

// File: rtl/display_controller.sv
// Six-digit seven-segment display controller.
// Converts a 20-bit unsigned value to BCD with a serial double-dabble engine
// (one bit per cycle, 20 cycles), then publishes digits, per-digit enables
// with optional leading-zero blanking, and a saturating overflow flag.
// Display outputs change only at the end of a complete conversion.
module display_controller #(
    parameter bit BLANK_LZ = 1'b1
) (
    input logic                 clk,
    input logic                 rst_n,
    display_controller_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Last iteration index of the SHIFT phase (one bit per input bit).
    localparam logic [4:0] LAST_STEP = 5'd19;

    // Add 3 to every BCD digit that is 5 or more, so the following left
    // shift carries correctly into the next decimal position.
    function automatic logic [27:0] dabble_adjust(input logic [27:0] s);
        logic [27:0] r;
        r = s;
        for (int d = 0; d < 7; d++) begin
            if (s[4*d +: 4] >= 4'd5) begin
                r[4*d +: 4] = s[4*d +: 4] + 4'd3;
            end else begin
                r[4*d +: 4] = s[4*d +: 4];
            end
        end
        return r;
    endfunction

    // Leading-zero blanking: a digit is lit if it or any more significant
    // digit is nonzero; the ones digit is always lit so zero shows as "0".
    function automatic logic [5:0] blank_mask(input logic [23:0] d);
        logic [5:0] m;
        logic       any_nz;
        m      = 6'b000000;
        any_nz = 1'b0;
        for (int i = 5; i >= 0; i--) begin
            any_nz = any_nz | (d[4*i +: 4] != 4'd0);
            m[i]   = any_nz | (i == 0);
        end
        return m;
    endfunction

    state_e      state_q, state_d;
    logic [19:0] bin_q, bin_d;
    logic [27:0] scratch_q, scratch_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [23:0] digits_q, digits_d;
    logic [5:0]  digit_en_q, digit_en_d;
    logic        overflow_q, overflow_d;
    logic        out_valid_q, out_valid_d;
    logic [27:0] adj_s;

    // Next-state and datapath update for the conversion FSM.
    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        scratch_d   = scratch_q;
        cnt_d       = cnt_q;
        digits_d    = digits_q;
        digit_en_d  = digit_en_q;
        overflow_d  = overflow_q;
        out_valid_d = 1'b0;
        adj_s       = dabble_adjust(scratch_q);

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    bin_d     = bus.in_value;
                    scratch_d = 28'd0;
                    cnt_d     = 5'd0;
                    state_d   = SHIFT;
                end else begin
                    state_d   = IDLE;
                end
            end

            SHIFT: begin
                {scratch_d, bin_d} = {adj_s[26:0], bin_q, 1'b0};
                if (cnt_q == LAST_STEP) begin
                    cnt_d   = 5'd0;
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + 5'd1;
                    state_d = SHIFT;
                end
            end

            DONE: begin
                if (scratch_q[27:24] != 4'd0) begin
                    // Seventh digit set: value >= 1000000, saturate display.
                    overflow_d = 1'b1;
                    digits_d   = 24'h999999;
                    digit_en_d = 6'b111111;
                end else begin
                    overflow_d = 1'b0;
                    digits_d   = scratch_q[23:0];
                    if (BLANK_LZ) begin
                        digit_en_d = blank_mask(scratch_q[23:0]);
                    end else begin
                        digit_en_d = 6'b111111;
                    end
                end
                out_valid_d = 1'b1;
                state_d     = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Conversion scratch and registered display outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_q       <= 20'd0;
            scratch_q   <= 28'd0;
            cnt_q       <= 5'd0;
            digits_q    <= 24'd0;
            digit_en_q  <= 6'b000001;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            bin_q       <= bin_d;
            scratch_q   <= scratch_d;
            cnt_q       <= cnt_d;
            digits_q    <= digits_d;
            digit_en_q  <= digit_en_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.digits    = digits_q;
    assign bus.digit_en  = digit_en_q;
    assign bus.overflow  = overflow_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: doc/display_controller.md
DISPLAY_CONTROLLER -- requirements
Module: display_controller

Interface
REQ-001 Parameter: BLANK_LZ, default 1, enables leading-zero blanking (1) or shows all six digits (0).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  requester presents a 20-bit binary value.
REQ-005 in_value  input  20  unsigned binary value to display.
REQ-006 in_ready  output  1  block can accept a value this cycle.
REQ-007 busy  output  1  conversion in progress.
REQ-008 digits  output  24  six BCD digits; [3:0] = ones, [23:20] = hundred-thousands.
REQ-009 digit_en  output  6  per-digit enable for the seven-segment drivers; bit i gates digits[4i+3:4i].
REQ-010 overflow  output  1  last converted value exceeded 999999.
REQ-011 out_valid  output  1  one-cycle pulse: digits, digit_en and overflow were updated.

Function
REQ-012 FSM states: IDLE, SHIFT, DONE; transitions occur only on the rising edge of clk.
REQ-013 IDLE: in_ready=1, busy=0; accept when in_valid=1. On accept: latch in_value, clear the 28-bit BCD scratch (7 digits), clear the iteration counter, go to SHIFT.
REQ-014 in_value is sampled only at the accept edge; later changes have no effect on the conversion in progress.
REQ-015 SHIFT: in_ready=0, busy=1. Each cycle performs one double-dabble step:
  - add 3 to every scratch BCD digit whose value is >=5;
  - then shift {scratch, binary} left by 1.
REQ-016 SHIFT lasts exactly 20 cycles (counter 0..19), then the FSM goes to DONE.
REQ-017 DONE lasts one cycle (in_ready=0, busy=1). At its exit edge the block:
  - registers digits, digit_en and overflow;
  - pulses out_valid for the following cycle;
  - returns to IDLE.
REQ-018 Latency: accept at edge k gives out_valid=1 in the cycle after edge k+21, when in_ready is also 1 again. Throughput: one conversion per 22 cycles.
REQ-019 overflow=1 iff scratch digit 6 is nonzero (value >= 1000000); then digits=24'h999999 (saturate) and digit_en=6'b111111.
REQ-020 No overflow: digits = scratch digits 5..0; overflow=0.
REQ-021 Blanking when BLANK_LZ=1: digit_en[i]=1 iff some digit j>=i is nonzero, or i=0; value 0 shows a single "0".
REQ-022 When BLANK_LZ=0: digit_en=6'b111111.
REQ-023 digits, digit_en and overflow hold their values between updates; the display never shows a partial conversion.
REQ-024 in_valid while busy (in_ready=0) is ignored, not queued; the requester holds in_valid until it sees in_ready=1.
REQ-025 in_valid=1 in the out_valid cycle is accepted (in_ready=1); back-to-back conversions are allowed.

Reset
REQ-026 While rst_n=0 at a clock edge the block enters IDLE and sets:
  - digits=0, digit_en=6'b000001, overflow=0, out_valid=0;
  - in_ready=1 from the next cycle, busy=0;
  - scratch and counter cleared.
REQ-027 Reset during SHIFT or DONE aborts the conversion: no out_valid and no update of the display outputs other than their reset values.

Verification
REQ-028 Accept in_value=0 -> after 21 cycles: out_valid=1, digits=24'h000000, digit_en=6'b000001, overflow=0.
REQ-029 Accept 123456 -> digits=24'h123456, digit_en=6'b111111, overflow=0; then 1000 -> digits=24'h001000, digit_en=6'b001111.
REQ-030 Accept 999999 -> digits=24'h999999, overflow=0. Accept 1000000 -> overflow=1, digits=24'h999999. Accept 20'hFFFFF (1048575) -> overflow=1.
REQ-031 Accept 42, then toggle in_value and in_valid during SHIFT -> in_ready stays 0, result digits=24'h000042, digit_en=6'b000011; 77 held on in_valid through the out_valid cycle is accepted immediately.
REQ-032 Accept 555555, assert rst_n=0 at the 10th SHIFT cycle -> no out_valid, outputs at reset values, in_ready=1; a new accept of 7 yields digits=24'h000007.
REQ-033 BLANK_LZ=0 build: accept 5 -> digits=24'h000005, digit_en=6'b111111.
